// File: rtl/interp_pkg.sv
// interp_pkg: row geometry, sample extraction and FIFO defaults for the interpolation datapath.
package interp_pkg;
  localparam int SAMPLE_W = 11;
  localparam int N_SAMPLES = 15;
  localparam int ROW_W = N_SAMPLES * SAMPLE_W;
  localparam int INTERP_FIFO_DEPTH = 8;
  function automatic logic signed [SAMPLE_W-1:0] get_sample(input logic [ROW_W-1:0] row, input int idx);
    return row[idx*SAMPLE_W +: SAMPLE_W];
  endfunction
endpackage

// File: rtl/interp_fifo_mem.sv
// interp_fifo_mem: DEPTH x ROW_W register array, one write port, asynchronous read port.
module interp_fifo_mem #(
  parameter int ROW_W = interp_pkg::ROW_W,
  parameter int DEPTH = interp_pkg::INTERP_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [ROW_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [ROW_W-1:0] rd_data
);
  logic [ROW_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/interp_row_fifo.sv
// interp_row_fifo: first-word-fall-through elastic row buffer between row mux and filter.
// Define INTERP_FIFO_LEVEL_EN to expose the registered occupancy on LEVEL.
module interp_row_fifo #(
  parameter int ROW_W = interp_pkg::ROW_W,
  parameter int DEPTH = interp_pkg::INTERP_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FLUSH,
  input  logic [ROW_W-1:0] IN_ROW,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [ROW_W-1:0] OUT_ROW,
  output logic             OUT_VALID,
`ifdef INTERP_FIFO_LEVEL_EN
  output logic [PTR_W:0]   LEVEL,
`endif
  input  logic             OUT_READY
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] count_q, count_d;
  logic push, pop;
  logic [ROW_W-1:0] head;
  always_comb begin
    IN_READY = count_q != FULL;
    OUT_VALID = count_q != '0;
    push = IN_VALID & IN_READY;
    pop = OUT_VALID & OUT_READY;
    OUT_ROW = OUT_VALID ? head : '0;
    wr_ptr_d = FLUSH ? '0 : wr_ptr_q + PTR_W'(push);
    rd_ptr_d = FLUSH ? '0 : rd_ptr_q + PTR_W'(pop);
    count_d = FLUSH ? '0 : count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  interp_fifo_mem #(.ROW_W(ROW_W), .DEPTH(DEPTH)) u_mem (
    .clk(CLK),
    .we(push & ~FLUSH),
    .wr_addr(wr_ptr_q),
    .wr_data(IN_ROW),
    .rd_addr(rd_ptr_q),
    .rd_data(head)
  );
`ifdef INTERP_FIFO_LEVEL_EN
  assign LEVEL = count_q;
`endif
endmodule

// File: tb/tb_interp_row_fifo.sv
// tb_interp_row_fifo: scoreboard bench for interp_row_fifo (directed cases plus per-cycle model).
module tb_interp_row_fifo;
  import interp_pkg::*;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [164:0] in_row = '0, out_row;
`ifdef INTERP_FIFO_LEVEL_EN
  logic [3:0] level;
`endif
  int n_cmp = 0, n_err = 0, n_pop = 0, n_neg = 0;
  logic [164:0] exp_q[$];
  logic [164:0] rows[20];
  logic prev_stall = 0;
  logic [164:0] prev_row = '0;
  always #5 clk = ~clk;
  interp_row_fifo dut (
    .CLK(clk),
    .RST_N(rst_n),
    .FLUSH(flush),
    .IN_ROW(in_row),
    .IN_VALID(in_valid),
    .IN_READY(in_ready),
    .OUT_ROW(out_row),
    .OUT_VALID(out_valid),
`ifdef INTERP_FIFO_LEVEL_EN
    .LEVEL(level),
`endif
    .OUT_READY(out_ready)
  );
  task automatic check(input string tag, input logic [164:0] got, input logic [164:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  assert property (@(posedge clk) disable iff (!rst_n) in_valid && !in_ready |=> $stable(in_row));
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      check("rst_valid", out_valid, 0);
      check("rst_row", out_row, 0);
      prev_stall = 0;
    end else begin
      check("m_in_ready", in_ready, exp_q.size() != 8);
      check("m_out_valid", out_valid, exp_q.size() != 0);
      check("m_head", out_row, exp_q.size() != 0 ? exp_q[0] : 165'h0);
`ifdef INTERP_FIFO_LEVEL_EN
      check("m_level", level, 165'(exp_q.size()));
`endif
      if (prev_stall) check("out_stable", out_row, prev_row);
      prev_stall = out_valid && !out_ready && !flush;
      prev_row = out_row;
      if (flush) exp_q.delete();
      else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("underflow", 1, 0);
          else begin
            check("sb_row", out_row, exp_q.pop_front());
            n_pop++;
            if (get_sample(out_row, 14) == -11'sd1024) n_neg++;
          end
        end
        if (in_valid && in_ready) exp_q.push_back(in_row);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic acc, tog;
    int sent;
    repeat (2) step();
    rst_n = 1;
    check("reset_ready", in_ready, 1);
`ifdef INTERP_FIFO_LEVEL_EN
    check("reset_level", level, 0);
`endif
    for (int k = 1; k <= 8; k++) begin
      in_row = 165'(k);
      in_valid = 1;
      step();
    end
    in_row = 165'd9;
    check("full_ready", in_ready, 0);
    check("full_head", out_row, 165'd1);
`ifdef INTERP_FIFO_LEVEL_EN
    check("full_level", level, 8);
`endif
    step();
    in_valid = 0;
    out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      check("drain_order", out_row, 165'(k));
      step();
    end
    check("drain_empty", out_valid, 0);
    out_ready = 0;
    in_row = {15{11'h2aa}};
    in_valid = 1;
    step();
    in_row = {15{11'h155}};
    out_ready = 1;
    check("pp1_head_a", out_row, {15{11'h2aa}});
    step();
    in_valid = 0;
    out_ready = 0;
    check("pp1_head_b", out_row, {15{11'h155}});
    check("pp1_valid", out_valid, 1);
`ifdef INTERP_FIFO_LEVEL_EN
    check("pp1_level", level, 1);
`endif
    out_ready = 1;
    step();
    out_ready = 0;
    for (int k = 1; k <= 8; k++) begin
      in_row = 165'(100 + k);
      in_valid = 1;
      step();
    end
    in_row = 165'd200;
    out_ready = 1;
    step();
    in_valid = 0;
    out_ready = 0;
    check("ppf_ready", in_ready, 1);
    check("ppf_head", out_row, 165'd102);
`ifdef INTERP_FIFO_LEVEL_EN
    check("ppf_level", level, 7);
`endif
    out_ready = 1;
    repeat (7) step();
    check("ppf_empty", out_valid, 0);
    out_ready = 0;
    for (int i = 0; i < 20; i++) rows[i] = 165'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    rows[5][164:154] = 11'h400;
    n_pop = 0;
    sent = 0;
    tog = 1;
    for (int c = 0; c < 100 && sent < 20; c++) begin
      in_row = rows[sent];
      in_valid = 1;
      out_ready = tog;
      tog = ~tog;
      acc = in_ready;
      step();
      if (acc) sent++;
    end
    in_valid = 0;
    out_ready = 1;
    for (int c = 0; c < 40 && out_valid; c++) step();
    check("wrap_sent", 165'(sent), 165'd20);
    check("wrap_pops", 165'(n_pop), 165'd20);
    check("wrap_neg1024", 165'(n_neg > 0), 1);
    repeat (3) step();
    check("empty_valid", out_valid, 0);
    check("empty_row", out_row, 0);
    out_ready = 0;
    in_row = 165'h1234_5678_9abc;
    in_valid = 1;
    step();
    in_valid = 0;
    out_ready = 1;
    check("single_row", out_row, 165'h1234_5678_9abc);
    step();
    check("single_gone", out_valid, 0);
    out_ready = 0;
    for (int k = 1; k <= 5; k++) begin
      in_row = 165'(300 + k);
      in_valid = 1;
      step();
    end
    in_row = 165'd999;
    flush = 1;
    out_ready = 1;
    step();
    flush = 0;
    in_valid = 0;
    out_ready = 0;
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 1);
    check("flush_row", out_row, 0);
`ifdef INTERP_FIFO_LEVEL_EN
    check("flush_level", level, 0);
`endif
    step();
    check("flush_discard", out_valid, 0);
    for (int k = 1; k <= 3; k++) begin
      in_row = 165'(400 + k);
      in_valid = 1;
      step();
    end
    in_valid = 0;
    #1 rst_n = 0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_row", out_row, 0);
    check("arst_ready", in_ready, 1);
`ifdef INTERP_FIFO_LEVEL_EN
    check("arst_level", level, 0);
`endif
    step();
    rst_n = 1;
    in_row = 165'h1;
    in_valid = 1;
    step();
    in_valid = 0;
    check("post_rst_row", out_row, 165'h1);
    check("post_rst_valid", out_valid, 1);
    out_ready = 1;
    step();
    check("post_rst_empty", out_valid, 0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
